// File: rtl/ahb_pkg.sv
// Shared AHB types and helpers for the bus arbiter: transfer/burst encodings and burst length lookup.
package ahb_pkg;

    localparam int unsigned MAX_MST = 4;
    localparam int unsigned MIDX_W  = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BEATS_W = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    // Undefined-length INCR counts as a single beat; it is re-arbitrated on every non-SEQ cycle.
    function automatic logic [BEATS_W-1:0] burst_beats(input hburst_t burst);
        logic [BEATS_W-1:0] beats;
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = BEATS_W'(4);
            HBURST_WRAP8,  HBURST_INCR8:  beats = BEATS_W'(8);
            HBURST_WRAP16, HBURST_INCR16: beats = BEATS_W'(16);
            default:                      beats = BEATS_W'(1);
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester after the pointer, pointer itself lowest priority.
module ahb_rr_picker
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MST = 4
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [MIDX_W-1:0]  pointer,
    output logic [NUM_MST-1:0] grant,
    output logic [MIDX_W-1:0]  idx,
    output logic               valid
);

    function automatic logic [MIDX_W-1:0] wrap_idx(input logic [MIDX_W-1:0] base,
                                                   input int unsigned     step);
        return MIDX_W'((32'(base) + step) % NUM_MST);
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 1; i <= NUM_MST; i++) begin
            if (!valid && req[wrap_idx(pointer, i)]) begin
                valid = 1'b1;
                idx   = wrap_idx(pointer, i);
            end
        end
        if (valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: burst-aware arbitration points, round-robin one-hot grant with lock hold,
// and address-phase owner tracking on hmaster/hmastlock.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MST = 4
) (
    input  logic               hclk,
    input  logic               hrst,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [NUM_MST-1:0] hlock,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hburst,
    input  logic               hreadyout,
    output logic [NUM_MST-1:0] hgrant,
    output logic [1:0]         hmaster,
    output logic               hmastlock
);

    htrans_t            trans_c;
    hburst_t            burst_c;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_load_c;
    logic [MIDX_W-1:0]  ptr;
    logic               arb_c;
    logic               owner_lock_c;
    logic [NUM_MST-1:0] pick_grant_c;
    logic [MIDX_W-1:0]  pick_idx_c;
    logic               pick_valid_c;
    logic [NUM_MST-1:0] next_grant_c;
    logic [MIDX_W-1:0]  next_idx_c;

    assign trans_c    = htrans_t'(htrans);
    assign burst_c    = hburst_t'(hburst);
    assign cnt_load_c = CNT_W'(burst_beats(burst_c) - BEATS_W'(1));

    // Remaining beats of the current fixed-length burst.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            cnt <= '0;
        end else if (hreadyout) begin
            if (trans_c == HTRANS_NONSEQ) begin
                cnt <= cnt_load_c;
            end else if (trans_c == HTRANS_SEQ && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Bus may change hands when the current beat completes a transfer or burst.
    assign arb_c = hreadyout &&
                   ((trans_c == HTRANS_IDLE) ||
                    (trans_c == HTRANS_NONSEQ && cnt_load_c == '0 && burst_c != HBURST_INCR) ||
                    (trans_c == HTRANS_SEQ && cnt == CNT_W'(1)) ||
                    (burst_c == HBURST_INCR && trans_c != HTRANS_SEQ));

    // ptr always holds the index of the granted master, so it doubles as the owner index.
    assign owner_lock_c = hlock[ptr];

    ahb_rr_picker #(
        .NUM_MST (NUM_MST)
    ) u_picker (
        .req     (hbusreq),
        .pointer (ptr),
        .grant   (pick_grant_c),
        .idx     (pick_idx_c),
        .valid   (pick_valid_c)
    );

    assign next_grant_c = pick_valid_c ? pick_grant_c : NUM_MST'(1);
    assign next_idx_c   = pick_valid_c ? pick_idx_c : '0;

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            hgrant <= NUM_MST'(1);
            ptr    <= '0;
        end else if (arb_c && !owner_lock_c && next_idx_c != ptr) begin
            hgrant <= next_grant_c;
            ptr    <= next_idx_c;
        end
    end

    // Address-phase ownership follows the grant once the bus is ready.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            hmaster   <= '0;
            hmastlock <= 1'b0;
        end else if (hreadyout) begin
            hmaster   <= ptr;
            hmastlock <= owner_lock_c;
        end
    end

endmodule
